// File: rtl/multi_cycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: ALU ops, FSM states,
// opcode/funct values and datapath select codes.
package multi_cycle_ctrl_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_ADDU = 4'd1,
    ALU_SUBU = 4'd2,
    ALU_AND  = 4'd3,
    ALU_OR   = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_LUI  = 4'd6,
    ALU_BEQ  = 4'd7,
    ALU_SRAV = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_t;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_RTEXE  = 4'd2,
    S_RTWB   = 4'd3,
    S_ITEXE  = 4'd4,
    S_ITWB   = 4'd5,
    S_MEMADR = 4'd6,
    S_MEMRD  = 4'd7,
    S_MEMWB  = 4'd8,
    S_MEMWR  = 4'd9,
    S_BEQ    = 4'd10,
    S_JMP    = 4'd11
  } state_t;

  typedef enum logic [2:0] {
    IC_ILLEGAL = 3'd0,
    IC_RTYPE   = 3'd1,
    IC_ITYPE   = 3'd2,
    IC_MEM     = 3'd3,
    IC_BEQ     = 3'd4,
    IC_JMP     = 3'd5
  } instr_class_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_SEXT = 2'b10;
  localparam logic [1:0] SRCB_ZEXT = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/multi_cycle_ctrl_alu_dec.sv
// Combinational instruction decode: classifies {opcode,funct} and picks the
// ALU operation / operand-B select used in the execute states.
module multi_cycle_ctrl_alu_dec
  import multi_cycle_ctrl_pkg::*;
(
  input  logic [5:0]   opcode,
  input  logic [5:0]   funct,
  output alu_op_t      exe_op,
  output logic [1:0]   exe_src_b,
  output instr_class_t iclass
);

  always_comb begin
    exe_op    = ALU_ADDU;
    exe_src_b = SRCB_B;
    iclass    = IC_ILLEGAL;
    case (opcode)
      OP_RTYPE: begin
        iclass = IC_RTYPE;
        case (funct)
          FN_ADD:  exe_op = ALU_ADD;
          FN_ADDU: exe_op = ALU_ADDU;
          FN_SUBU: exe_op = ALU_SUBU;
          FN_AND:  exe_op = ALU_AND;
          FN_OR:   exe_op = ALU_OR;
          FN_SLT:  exe_op = ALU_SLT;
          FN_SLTU: exe_op = ALU_SLTU;
          FN_SRAV: exe_op = ALU_SRAV;
          default: iclass = IC_ILLEGAL;
        endcase
      end
      OP_LW, OP_SW: begin
        iclass    = IC_MEM;
        exe_op    = ALU_ADD;
        exe_src_b = SRCB_SEXT;
      end
      OP_BEQ: begin
        iclass = IC_BEQ;
        exe_op = ALU_SUBU;
      end
      OP_J:    iclass = IC_JMP;
      OP_ADDIU: begin
        iclass    = IC_ITYPE;
        exe_op    = ALU_ADDU;
        exe_src_b = SRCB_SEXT;
      end
      OP_ORI: begin
        iclass    = IC_ITYPE;
        exe_op    = ALU_OR;
        exe_src_b = SRCB_ZEXT;
      end
      OP_LUI: begin
        iclass    = IC_ITYPE;
        exe_op    = ALU_LUI;
        exe_src_b = SRCB_ZEXT;
      end
      default: iclass = IC_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Control FSM for the multi-cycle MIPS datapath: sequences fetch/decode/execute/
// memory/writeback and stalls memory stages on the ready handshake.
module multi_cycle_ctrl
  import multi_cycle_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_src,
  output logic       reg_we,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [3:0] alu_op,
  output logic       illegal,
  output logic [3:0] state
);

  state_t       state_q;
  state_t       next_state;
  alu_op_t      alu_op_c;
  alu_op_t      exe_op;
  logic [1:0]   exe_src_b;
  instr_class_t iclass;

  multi_cycle_ctrl_alu_dec u_alu_dec (
    .opcode    (opcode),
    .funct     (funct),
    .exe_op    (exe_op),
    .exe_src_b (exe_src_b),
    .iclass    (iclass)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= next_state;
  end

  assign state  = state_q;
  assign alu_op = alu_op_c;

  // Outputs decode state combinationally and are gated by rst so enables drop
  // the moment reset asserts, not at the next clock edge.
  always_comb begin
    next_state = S_FETCH;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_src     = PCSRC_ALU;
    reg_we     = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_B;
    alu_op_c   = ALU_ADDU;
    illegal    = 1'b0;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          mem_req    = 1'b1;
          alu_src_b  = SRCB_FOUR;
          ir_we      = mem_ready;
          pc_we      = mem_ready;
          next_state = mem_ready ? S_DECODE : S_FETCH;
        end
        S_DECODE: begin
          alu_src_b = SRCB_SEXT;
          alu_op_c  = ALU_BEQ;
          case (iclass)
            IC_RTYPE: next_state = S_RTEXE;
            IC_ITYPE: next_state = S_ITEXE;
            IC_MEM:   next_state = S_MEMADR;
            IC_BEQ:   next_state = S_BEQ;
            IC_JMP:   next_state = S_JMP;
            default: begin
              illegal    = 1'b1;
              next_state = S_FETCH;
            end
          endcase
        end
        S_RTEXE: begin
          alu_src_a  = 1'b1;
          alu_src_b  = SRCB_B;
          alu_op_c   = exe_op;
          next_state = S_RTWB;
        end
        S_RTWB: begin
          reg_we  = 1'b1;
          reg_dst = 1'b1;
        end
        S_ITEXE: begin
          alu_src_a  = 1'b1;
          alu_src_b  = exe_src_b;
          alu_op_c   = exe_op;
          next_state = S_ITWB;
        end
        S_ITWB: reg_we = 1'b1;
        S_MEMADR: begin
          alu_src_a  = 1'b1;
          alu_src_b  = SRCB_SEXT;
          alu_op_c   = ALU_ADD;
          next_state = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
        end
        S_MEMRD: begin
          mem_req    = 1'b1;
          iord       = 1'b1;
          next_state = mem_ready ? S_MEMWB : S_MEMRD;
        end
        S_MEMWB: begin
          reg_we     = 1'b1;
          mem_to_reg = 1'b1;
        end
        S_MEMWR: begin
          mem_req    = 1'b1;
          mem_we     = 1'b1;
          iord       = 1'b1;
          next_state = mem_ready ? S_FETCH : S_MEMWR;
        end
        S_BEQ: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_B;
          alu_op_c  = ALU_SUBU;
          pc_src    = PCSRC_ALUOUT;
          pc_we     = zero;
        end
        S_JMP: begin
          pc_src = PCSRC_JUMP;
          pc_we  = 1'b1;
        end
        default: next_state = S_FETCH;
      endcase
    end
  end

endmodule
